edac_scrub_arb: RTL and testbench
=================================

EDAC_SCRUB_ARB -- requirements
Module: edac_scrub_arb

Interface
REQ-001 SHALL have parameter DAT_WIDTH, default 16: user data bits per word.
REQ-002 SHALL have parameter PAR_WIDTH, default 6: check bits per word; CW = DAT_WIDTH+PAR_WIDTH.
REQ-003 SHALL have parameter RAM_LOGDEPTH, default 8: RAM address width.
REQ-004 SHALL have parameters SCRUB_AMIN, default 0, and SCRUB_AMAX, default 255: inclusive scrub address range.
REQ-005 SHALL have parameter DEC_LAT, default 2: cycles from ram_rEn to valid dec_* inputs, range 1..7.
REQ-006 SHALL have parameter DIV_WDTH, default 20: scrub-period timer width.
REQ-007 SHALL have parameter TMOUT_SET, default 10: consecutive blocked cycles before tmoutflg.
REQ-008 SHALL have parameter CNT_WDTH, default 8: error counter width.
REQ-009 SHALL have ports: clk in 1, sole clock; rst in 1, synchronous active-high reset.
REQ-010 SHALL have ports: user_rEn in 1, user_rA in RAM_LOGDEPTH, user_wEn in 1, user_wA in RAM_LOGDEPTH, user_wD in CW: encoded user traffic.
REQ-011 SHALL have ports: start_scrub in 1, stop_scrub in 1, clr_log in 1: control.
REQ-012 SHALL have ports: dec_code in CW, dec_err in 1, dec_corr in 1: decoder corrected word and flags.
REQ-013 SHALL have ports: ram_rEn out 1, ram_rA out RAM_LOGDEPTH, ram_wEn out 1, ram_wA out RAM_LOGDEPTH, ram_wD out CW.
REQ-014 SHALL have ports: now_scrubbing out 1, scrub_done out 1, tmoutflg out 1, corr_cnt out CNT_WDTH, uncorr_cnt out CNT_WDTH, err_addr out RAM_LOGDEPTH, err_vld out 1.

Function
REQ-015 SHALL pass user ports to RAM ports combinationally whenever the FSM does not own the port; user access always wins.
REQ-016 SHALL run a free timer of DIV_WDTH bits; terminal count or start_scrub pulse sets scrub_due, cleared on entering READ.
REQ-017 SHALL implement FSM IDLE, READ, WAIT, WRBK, DONE; IDLE->READ when scrub_due & ~stop_scrub.
REQ-018 READ SHALL drive ram_rEn=1, ram_rA=scrub address only in a cycle with user_rEn=0; otherwise hold in READ.
REQ-019 WAIT SHALL last DEC_LAT cycles, then sample dec_err/dec_corr.
REQ-020 On dec_err&dec_corr SHALL increment corr_cnt and go WRBK; on dec_err&~dec_corr SHALL increment uncorr_cnt and advance; else advance.
REQ-021 WRBK SHALL drive ram_wEn=1, ram_wA=scrub address, ram_wD=captured dec_code in a cycle with user_wEn=0; otherwise hold.
REQ-022 A user write to the scrub address during WAIT or WRBK SHALL cancel the write-back (counter still incremented).
REQ-023 Advance SHALL increment address; at SCRUB_AMAX SHALL wrap to SCRUB_AMIN and go DONE.
REQ-024 DONE SHALL pulse scrub_done for exactly 1 cycle and return to IDLE.
REQ-025 now_scrubbing SHALL be 1 in every state except IDLE.
REQ-026 stop_scrub SHALL let a pending WAIT/WRBK finish, then park in IDLE retaining address; deassertion resumes from it.
REQ-027 Counters SHALL saturate at all-ones; clr_log SHALL zero both counters and err_vld.
REQ-028 The first uncorrectable address SHALL be latched in err_addr with err_vld=1; later ones SHALL not overwrite until clr_log.
REQ-029 A blocked-cycle counter SHALL set tmoutflg when TMOUT_SET consecutive READ/WRBK cycles are blocked; cleared on next granted scrub access.
REQ-030 Simultaneous clr_log and error event SHALL leave the new event counted/logged.

Reset
REQ-031 rst SHALL set FSM IDLE, address SCRUB_AMIN, timer 0, scrub_due 0, all counters 0, err_addr 0, err_vld/tmoutflg/scrub_done/now_scrubbing 0.
REQ-032 rst mid-scrub SHALL abort without issuing any further RAM write.

Configuration
REQ-033 Macro EDAC_SCRUB_WRBK_EN defined: WRBK state present as above; undefined: WRBK removed, correctable words only counted, FSM never asserts ram_wEn.

Verification
REQ-034 start_scrub, AMIN=0, AMAX=3, clean RAM -> 4 reads addresses 0..3, scrub_done one pulse, counters 0.
REQ-035 Address 2 returns dec_err=1, dec_corr=1 -> corr_cnt=1, one write to address 2 with dec_code (no write without macro).
REQ-036 Address 1 uncorrectable, then address 3 uncorrectable -> uncorr_cnt=2, err_addr=1, err_vld=1; clr_log -> 0/0.
REQ-037 user_rEn held 10 cycles during READ, TMOUT_SET=10 -> tmoutflg=1 on 10th blocked cycle, cleared after grant.
REQ-038 User write to address 2 during WAIT with correctable error -> no scrub write to address 2.
REQ-039 stop_scrub at address 2 then released -> scrub resumes at 3; rst in WRBK -> no ram_wEn after reset edge.

Source files
------------

// File: rtl/edac_scrub_arb_if.sv
// RAM-side bus of the EDAC scrub arbiter: user traffic in, decoder results in, RAM port out.
interface edac_scrub_arb_if #(
   parameter int RAM_LOGDEPTH = 8,
   parameter int CW           = 22
);
   logic                    user_rEn;
   logic [RAM_LOGDEPTH-1:0] user_rA;
   logic                    user_wEn;
   logic [RAM_LOGDEPTH-1:0] user_wA;
   logic [CW-1:0]           user_wD;

   logic [CW-1:0]           dec_code;
   logic                    dec_err;
   logic                    dec_corr;

   logic                    ram_rEn;
   logic [RAM_LOGDEPTH-1:0] ram_rA;
   logic                    ram_wEn;
   logic [RAM_LOGDEPTH-1:0] ram_wA;
   logic [CW-1:0]           ram_wD;

   // Handshake: enables are single-cycle strobes with no ready; a user strobe is always
   // forwarded to the RAM the same cycle, and the scrubber only uses a port in cycles
   // where the matching user strobe is low.
   modport slave (
      input  user_rEn, user_rA, user_wEn, user_wA, user_wD,
      input  dec_code, dec_err, dec_corr,
      output ram_rEn, ram_rA, ram_wEn, ram_wA, ram_wD
   );

   modport master (
      output user_rEn, user_rA, user_wEn, user_wA, user_wD,
      output dec_code, dec_err, dec_corr,
      input  ram_rEn, ram_rA, ram_wEn, ram_wA, ram_wD
   );
endinterface

// File: rtl/edac_scrub_arb.sv
// Background EDAC scrubber sharing a RAM port with user traffic (user always wins).
// Define EDAC_SCRUB_WRBK_EN to write corrected words back; otherwise they are only counted.
module edac_scrub_arb #(
   parameter int DAT_WIDTH    = 16,
   parameter int PAR_WIDTH    = 6,
   parameter int RAM_LOGDEPTH = 8,
   parameter int SCRUB_AMIN   = 0,
   parameter int SCRUB_AMAX   = 255,
   parameter int DEC_LAT      = 2,
   parameter int DIV_WDTH     = 20,
   parameter int TMOUT_SET    = 10,
   parameter int CNT_WDTH     = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   edac_scrub_arb_if.slave         bus,
   input  logic                    start_scrub,
   input  logic                    stop_scrub,
   input  logic                    clr_log,
   output logic                    now_scrubbing,
   output logic                    scrub_done,
   output logic                    tmoutflg,
   output logic [CNT_WDTH-1:0]     corr_cnt,
   output logic [CNT_WDTH-1:0]     uncorr_cnt,
   output logic [RAM_LOGDEPTH-1:0] err_addr,
   output logic                    err_vld,
   output logic [2:0]              dbg_state
);
   localparam int                    CW       = DAT_WIDTH + PAR_WIDTH;
   localparam int                    AW       = RAM_LOGDEPTH;
   localparam logic [AW-1:0]         AMIN     = AW'(SCRUB_AMIN);
   localparam logic [AW-1:0]         AMAX     = AW'(SCRUB_AMAX);
   localparam logic [2:0]            LAT_LAST = 3'(DEC_LAT - 1);
   localparam int                    BLK_W    = $clog2(TMOUT_SET + 1);
   localparam logic [BLK_W-1:0]      BLK_LAST = BLK_W'(TMOUT_SET - 1);
   localparam logic [CNT_WDTH-1:0]   CNT_ONE  = CNT_WDTH'(1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      WAIT = 3'd2,
`ifdef EDAC_SCRUB_WRBK_EN
      WRBK = 3'd4,
`endif
      DONE = 3'd3
   } state_t;

   state_t               state_q, state_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic [2:0]           lat_q, lat_d;
   logic                 cancel_q, cancel_d;
   logic                 parked_q, parked_d;
   logic [CW-1:0]        code_q;
   logic                 scrub_due_q;
   logic [DIV_WDTH-1:0]  timer_q;
   logic [BLK_W-1:0]     blk_q;
   logic                 tmout_q;
   logic [CNT_WDTH-1:0]  corr_q, uncorr_q;
   logic [AW-1:0]        err_addr_q;
   logic                 err_vld_q;

   logic fsm_rd, fsm_wr, blocked, granted, advance;
   logic corr_evt, uncorr_evt, user_hit;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      lat_d      = lat_q;
      cancel_d   = cancel_q;
      parked_d   = parked_q;
      fsm_rd     = 1'b0;
      fsm_wr     = 1'b0;
      blocked    = 1'b0;
      granted    = 1'b0;
      advance    = 1'b0;
      corr_evt   = 1'b0;
      uncorr_evt = 1'b0;
      user_hit   = bus.user_wEn && (bus.user_wA == addr_q);
      case (state_q)
         // parked_q remembers a stop so that release resumes without a new trigger
         IDLE: begin
            if ((scrub_due_q || parked_q) && !stop_scrub) begin
               state_d  = READ;
               parked_d = 1'b0;
            end
         end
         READ: begin
            if (stop_scrub) begin
               state_d  = IDLE;
               parked_d = 1'b1;
            end else if (bus.user_rEn) begin
               blocked = 1'b1;
            end else begin
               fsm_rd   = 1'b1;
               granted  = 1'b1;
               state_d  = WAIT;
               lat_d    = 3'd0;
               cancel_d = 1'b0;
            end
         end
         WAIT: begin
            cancel_d = cancel_q | user_hit;
            if (lat_q == LAT_LAST) begin
               if (bus.dec_err && bus.dec_corr) begin
                  corr_evt = 1'b1;
`ifdef EDAC_SCRUB_WRBK_EN
                  if (cancel_q || user_hit) advance = 1'b1;
                  else                      state_d = WRBK;
`else
                  advance = 1'b1;
`endif
               end else begin
                  uncorr_evt = bus.dec_err;
                  advance    = 1'b1;
               end
            end else begin
               lat_d = lat_q + 3'd1;
            end
         end
`ifdef EDAC_SCRUB_WRBK_EN
         // A user write to the same word makes our corrected copy stale: drop it.
         WRBK: begin
            if (user_hit) begin
               advance = 1'b1;
            end else if (bus.user_wEn) begin
               blocked = 1'b1;
            end else begin
               fsm_wr  = !rst;
               granted = 1'b1;
               advance = 1'b1;
            end
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (advance) begin
         if (addr_q == AMAX) begin
            addr_d  = AMIN;
            state_d = DONE;
         end else begin
            addr_d  = addr_q + 1'b1;
            state_d = READ;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= AMIN;
         lat_q       <= 3'd0;
         cancel_q    <= 1'b0;
         parked_q    <= 1'b0;
         code_q      <= '0;
         scrub_due_q <= 1'b0;
         timer_q     <= '0;
         blk_q       <= '0;
         tmout_q     <= 1'b0;
         corr_q      <= '0;
         uncorr_q    <= '0;
         err_addr_q  <= '0;
         err_vld_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         lat_q    <= lat_d;
         cancel_q <= cancel_d;
         parked_q <= parked_d;
         timer_q  <= timer_q + 1'b1;

         if (state_q == IDLE && state_d == READ)  scrub_due_q <= 1'b0;
         else if (start_scrub || (&timer_q))      scrub_due_q <= 1'b1;

         if (granted) begin
            blk_q   <= '0;
            tmout_q <= 1'b0;
         end else if (blocked) begin
            if (blk_q == BLK_LAST) tmout_q <= 1'b1;
            else                   blk_q   <= blk_q + 1'b1;
         end

         if (corr_evt) code_q <= bus.dec_code;

         // An event coinciding with clr_log survives the clear.
         if (corr_evt)     corr_q <= clr_log ? CNT_ONE : ((&corr_q) ? corr_q : corr_q + 1'b1);
         else if (clr_log) corr_q <= '0;

         if (uncorr_evt)   uncorr_q <= clr_log ? CNT_ONE : ((&uncorr_q) ? uncorr_q : uncorr_q + 1'b1);
         else if (clr_log) uncorr_q <= '0;

         if (uncorr_evt && (!err_vld_q || clr_log)) begin
            err_addr_q <= addr_q;
            err_vld_q  <= 1'b1;
         end else if (clr_log) begin
            err_vld_q  <= 1'b0;
         end
      end
   end

   assign bus.ram_rEn = bus.user_rEn | fsm_rd;
   assign bus.ram_rA  = fsm_rd ? addr_q : bus.user_rA;
   assign bus.ram_wEn = bus.user_wEn | fsm_wr;
   assign bus.ram_wA  = fsm_wr ? addr_q : bus.user_wA;
   assign bus.ram_wD  = fsm_wr ? code_q : bus.user_wD;

   assign now_scrubbing = (state_q != IDLE);
   assign scrub_done    = (state_q == DONE);
   assign tmoutflg      = tmout_q;
   assign corr_cnt      = corr_q;
   assign uncorr_cnt    = uncorr_q;
   assign err_addr      = err_addr_q;
   assign err_vld       = err_vld_q;
   assign dbg_state     = state_q;
endmodule

// File: tb/tb_edac_scrub_arb.sv
// Directed bench for edac_scrub_arb over a 4-word scrub window with a table-driven decoder model.
module tb_edac_scrub_arb;
   localparam int AW = 8;
   localparam int CW = 22;
   localparam logic [CW-1:0] CODE_BASE = 22'h3C0000;
   localparam logic [2:0] S_IDLE = 3'd0, S_READ = 3'd1, S_WAIT = 3'd2, S_DONE = 3'd3, S_WRBK = 3'd4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_scrub = 1'b0, stop_scrub = 1'b0, clr_log = 1'b0;
   logic now_scrubbing, scrub_done, tmoutflg, err_vld;
   logic [7:0] corr_cnt, uncorr_cnt;
   logic [AW-1:0] err_addr;
   logic [2:0] dbg_state;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [AW-1:0] last_rd = '0;
   logic [AW-1:0] rd_q[$];
   logic [AW+CW-1:0] wr_q[$];
   logic [AW-1:0] exp_q[$];

   always #5 clk = ~clk;

   edac_scrub_arb_if #(.RAM_LOGDEPTH(AW), .CW(CW)) bus ();

   edac_scrub_arb #(
      .DAT_WIDTH(16), .PAR_WIDTH(6), .RAM_LOGDEPTH(AW), .SCRUB_AMIN(0), .SCRUB_AMAX(3),
      .DEC_LAT(2), .DIV_WDTH(20), .TMOUT_SET(10), .CNT_WDTH(8)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .start_scrub(start_scrub), .stop_scrub(stop_scrub),
      .clr_log(clr_log), .now_scrubbing(now_scrubbing), .scrub_done(scrub_done),
      .tmoutflg(tmoutflg), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt),
      .err_addr(err_addr), .err_vld(err_vld), .dbg_state(dbg_state)
   );

   // Decoder model: result for the word read DEC_LAT=2 cycles earlier; err_tab = {err, corr}
   logic [1:0] err_tab [0:255];
   logic p1_v = 1'b0, p2_v = 1'b0;
   logic [AW-1:0] p1_a = '0, p2_a = '0;
   always @(posedge clk) begin
      p1_v <= bus.ram_rEn;
      p1_a <= bus.ram_rA;
      p2_v <= p1_v;
      p2_a <= p1_a;
   end
   assign bus.dec_err  = p2_v & err_tab[p2_a][1];
   assign bus.dec_corr = p2_v & err_tab[p2_a][0];
   assign bus.dec_code = CODE_BASE | CW'(p2_a);

   // Monitor just before each rising edge: scrubber-owned RAM accesses and done pulses
   always begin
      @(negedge clk);
      #2;
      if (scrub_done) done_cnt++;
      if (bus.ram_rEn && !bus.user_rEn) begin
         rd_q.push_back(bus.ram_rA);
         last_rd = bus.ram_rA;
      end
      if (bus.ram_wEn && !bus.user_wEn) wr_q.push_back({bus.ram_wA, bus.ram_wD});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reads(input string tag);
      check({tag, "_nrd"}, rd_q.size(), exp_q.size());
      foreach (exp_q[i])
         if (i < rd_q.size()) check({tag, "_rdaddr"}, 32'(rd_q[i]), 32'(exp_q[i]));
   endtask

   task automatic pulse_start();
      start_scrub = 1'b1;
      @(negedge clk);
      start_scrub = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int d0);
      bit seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (done_cnt != d0) seen = 1'b1;
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic wait_for(input logic [2:0] s, input bit use_a, input logic [AW-1:0] a,
                           input string tag);
      bit hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
         @(negedge clk);
         if (dbg_state == s && (!use_a || last_rd == a)) hit = 1'b1;
      end
      check({tag, "_reached"}, 32'(hit), 32'd1);
   endtask

   task automatic clear_logs();
      rd_q.delete();
      wr_q.delete();
   endtask

   initial begin
      int d0;
      for (int i = 0; i < 256; i++) err_tab[i] = 2'b00;
      bus.user_rEn = 1'b0; bus.user_rA = '0;
      bus.user_wEn = 1'b0; bus.user_wA = '0; bus.user_wD = '0;
      exp_q = '{8'd0, 8'd1, 8'd2, 8'd3};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_state", 32'(dbg_state), 32'(S_IDLE));
      check("rst_now_scrubbing", 32'(now_scrubbing), 32'd0);
      check("rst_scrub_done", 32'(scrub_done), 32'd0);
      check("rst_tmoutflg", 32'(tmoutflg), 32'd0);
      check("rst_corr_cnt", 32'(corr_cnt), 32'd0);
      check("rst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
      check("rst_err_addr", 32'(err_addr), 32'd0);
      check("rst_err_vld", 32'(err_vld), 32'd0);
      check("rst_ram_wEn", 32'(bus.ram_wEn), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // User passthrough while idle
      bus.user_rEn = 1'b1; bus.user_rA = 8'h5A;
      bus.user_wEn = 1'b1; bus.user_wA = 8'hC3; bus.user_wD = 22'h155AA;
      #1;
      check("pass_rEn", 32'(bus.ram_rEn), 32'd1);
      check("pass_rA", 32'(bus.ram_rA), 32'h5A);
      check("pass_wEn", 32'(bus.ram_wEn), 32'd1);
      check("pass_wA", 32'(bus.ram_wA), 32'hC3);
      check("pass_wD", 32'(bus.ram_wD), 32'h155AA);
      @(negedge clk);
      bus.user_rEn = 1'b0; bus.user_wEn = 1'b0;
      @(negedge clk);

      // Clean scan of 0..3
      clear_logs();
      d0 = done_cnt;
      pulse_start();
      wait_done("clean", d0);
      repeat (4) @(negedge clk);
      check_reads("clean");
      check("clean_done_pulses", 32'(done_cnt - d0), 32'd1);
      check("clean_writes", wr_q.size(), 32'd0);
      check("clean_corr", 32'(corr_cnt), 32'd0);
      check("clean_uncorr", 32'(uncorr_cnt), 32'd0);
      check("clean_idle", 32'(now_scrubbing), 32'd0);

      // Correctable word at address 2
      err_tab[2] = 2'b11;
      clear_logs();
      d0 = done_cnt;
      pulse_start();
      wait_done("corr", d0);
      @(negedge clk);
      check_reads("corr");
      check("corr_cnt", 32'(corr_cnt), 32'd1);
      check("corr_uncorr", 32'(uncorr_cnt), 32'd0);
`ifdef EDAC_SCRUB_WRBK_EN
      check("corr_nwr", wr_q.size(), 32'd1);
      if (wr_q.size() > 0) check("corr_wr", 32'(wr_q[0]), 32'({8'd2, CODE_BASE | 22'd2}));
`else
      check("corr_nwr", wr_q.size(), 32'd0);
`endif
      err_tab[2] = 2'b00;

      // Uncorrectable at 1 and 3: first address latched
      err_tab[1] = 2'b10;
      err_tab[3] = 2'b10;
      clear_logs();
      d0 = done_cnt;
      pulse_start();
      wait_done("uncorr", d0);
      @(negedge clk);
      check("uncorr_cnt", 32'(uncorr_cnt), 32'd2);
      check("uncorr_corr_kept", 32'(corr_cnt), 32'd1);
      check("uncorr_err_addr", 32'(err_addr), 32'd1);
      check("uncorr_err_vld", 32'(err_vld), 32'd1);
      check("uncorr_nwr", wr_q.size(), 32'd0);
      clr_log = 1'b1;
      @(negedge clk);
      clr_log = 1'b0;
      check("clr_corr", 32'(corr_cnt), 32'd0);
      check("clr_uncorr", 32'(uncorr_cnt), 32'd0);
      check("clr_err_vld", 32'(err_vld), 32'd0);
      err_tab[1] = 2'b00;
      err_tab[3] = 2'b00;

      // Read port blocked by user for 10 cycles
      bus.user_rEn = 1'b1; bus.user_rA = 8'h77;
      clear_logs();
      d0 = done_cnt;
      pulse_start();
      wait_for(S_READ, 1'b0, '0, "tmo_read");
      repeat (9) @(negedge clk);
      check("tmo_after9", 32'(tmoutflg), 32'd0);
      @(negedge clk);
      check("tmo_after10", 32'(tmoutflg), 32'd1);
      bus.user_rEn = 1'b0;
      @(negedge clk);
      check("tmo_cleared", 32'(tmoutflg), 32'd0);
      check("tmo_state_wait", 32'(dbg_state), 32'(S_WAIT));
      wait_done("tmo", d0);
      @(negedge clk);
      check_reads("tmo");

      // User write to address 2 while it waits on a correctable result
      err_tab[2] = 2'b11;
      clear_logs();
      d0 = done_cnt;
      pulse_start();
      wait_for(S_WAIT, 1'b1, 8'd2, "cancel_wait");
      bus.user_wEn = 1'b1; bus.user_wA = 8'd2; bus.user_wD = 22'h3FFFF;
      @(negedge clk);
      bus.user_wEn = 1'b0;
      wait_done("cancel", d0);
      @(negedge clk);
      check("cancel_nwr", wr_q.size(), 32'd0);
      check("cancel_corr", 32'(corr_cnt), 32'd1);
      err_tab[2] = 2'b00;

      // Stop at address 2, then resume at 3
      clear_logs();
      d0 = done_cnt;
      pulse_start();
      wait_for(S_WAIT, 1'b1, 8'd2, "stop_wait");
      check("stop_busy", 32'(now_scrubbing), 32'd1);
      stop_scrub = 1'b1;
      repeat (8) @(negedge clk);
      check("stop_parked", 32'(dbg_state), 32'(S_IDLE));
      check("stop_nrd", rd_q.size(), 32'd3);
      check("stop_no_done", 32'(done_cnt - d0), 32'd0);
      stop_scrub = 1'b0;
      wait_done("resume", d0);
      @(negedge clk);
      check("resume_nrd", rd_q.size(), 32'd4);
      if (rd_q.size() > 3) check("resume_addr", 32'(rd_q[3]), 32'd3);

      // Reset mid-scrub: no scrub write afterwards, address back at AMIN
      err_tab[1] = 2'b11;
      clear_logs();
      pulse_start();
`ifdef EDAC_SCRUB_WRBK_EN
      wait_for(S_WRBK, 1'b1, 8'd1, "rstmid_wrbk");
`else
      wait_for(S_WAIT, 1'b1, 8'd1, "rstmid_wait");
`endif
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      err_tab[1] = 2'b00;
      repeat (5) @(negedge clk);
      check("rstmid_nwr", wr_q.size(), 32'd0);
      check("rstmid_state", 32'(dbg_state), 32'(S_IDLE));
      check("rstmid_corr", 32'(corr_cnt), 32'd0);
      clear_logs();
      d0 = done_cnt;
      pulse_start();
      wait_done("after_rst", d0);
      @(negedge clk);
      check_reads("after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
